// File: rtl/packet_buffer_reader.sv
// Streams len bytes from the packet buffer, one read per BYTE_PERIOD cycles, wrapping at RAM_SIZE.
// Latency from read issue to outclk is READ_LATENCY+1; there is no backpressure (fixed cadence), abort drains in-flight reads silently.
module packet_buffer_reader #(
  parameter int RAM_SIZE     = 16,
  parameter int READ_LATENCY = 2,
  parameter int BYTE_PERIOD  = 4,
  parameter int BYTE_LEN     = 8,
  localparam int AW = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1,
  localparam int IW = $clog2(READ_LATENCY / BYTE_PERIOD + 2),
  localparam int PW = (BYTE_PERIOD > 1) ? $clog2(BYTE_PERIOD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       start_addr,
  input  logic [AW:0]         len,
  input  logic                abort,
  output logic                ram_readclk,
  output logic [AW-1:0]       ram_raddr,
  input  logic                ram_outclk,
  input  logic [BYTE_LEN-1:0] ram_out,
  output logic                outclk,
  output logic [BYTE_LEN-1:0] out,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state;
  logic [AW:0]   remaining;
  logic [AW-1:0] next_addr;
  logic [PW-1:0] pace;
  logic [IW-1:0] inflight;
  logic          aborted;

  // eff counts the read being strobed this cycle too, so a zero-latency return is still legal
  logic [IW:0] eff;
  logic [IW:0] eff_next;
  logic        rd_ret;

  assign eff      = {1'b0, inflight} + {{IW{1'b0}}, ram_readclk};
  assign rd_ret   = ram_outclk && (eff != '0);
  assign eff_next = eff - {{IW{1'b0}}, rd_ret};

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == AW'(RAM_SIZE - 1)) ? '0 : a + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ram_readclk <= 1'b0;
      ram_raddr   <= '0;
      outclk      <= 1'b0;
      out         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      remaining   <= '0;
      next_addr   <= '0;
      pace        <= '0;
      inflight    <= '0;
      aborted     <= 1'b0;
    end else begin
      ram_readclk <= 1'b0;
      outclk      <= 1'b0;
      done        <= 1'b0;
      inflight    <= eff_next[IW-1:0];

      // Once DRAIN is entered without abort, the last return is byte len
      if (rd_ret && !aborted && !abort && state != IDLE) begin
        out    <= ram_out;
        outclk <= 1'b1;
        if (state == DRAIN && eff_next == '0)
          done <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            aborted <= 1'b0;
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              ram_readclk <= 1'b1;
              ram_raddr   <= start_addr;
              next_addr   <= wrap_inc(start_addr);
              remaining   <= len - 1'b1;
              pace        <= PW'(BYTE_PERIOD - 1);
              busy        <= 1'b1;
              state       <= (len == (AW+1)'(1)) ? DRAIN : ISSUE;
            end
          end
        end

        ISSUE: begin
          if (abort) begin
            aborted <= 1'b1;
            if (eff_next == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else if (pace == '0) begin
            ram_readclk <= 1'b1;
            ram_raddr   <= next_addr;
            next_addr   <= wrap_inc(next_addr);
            remaining   <= remaining - 1'b1;
            pace        <= PW'(BYTE_PERIOD - 1);
            if (remaining == (AW+1)'(1))
              state <= DRAIN;
          end else begin
            pace <= pace - 1'b1;
          end
        end

        DRAIN: begin
          if (abort)
            aborted <= 1'b1;
          if (eff_next == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/packet_buffer_reader.md
Name: packet_buffer_reader

Overview:
Downstream consumer of packet_buffer_ram_driver. On a start pulse it streams a packet of len bytes out of the packet buffer, beginning at start_addr. It issues one read per BYTE_PERIOD cycles, wrapping at RAM_SIZE, and re-emits the returned bytes as a clock-enable-qualified byte stream. It sits between the packet buffer and the TX byte serializer, which consumes one byte per BYTE_PERIOD cycles (RMII: 4 cycles/byte).

Parameters:
RAM_SIZE, PACKET_BUFFER_SIZE, depth of the packet buffer in bytes (need not be a power of two).
READ_LATENCY, PACKET_BUFFER_READ_LATENCY, cycles from ram_readclk to ram_outclk in the driver.
BYTE_PERIOD, 4, cycles between consecutive read issues; must be >= 1.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request; accepted only when busy=0.
start_addr  in  clog2(RAM_SIZE)  first byte address, must be < RAM_SIZE.
len  in  clog2(RAM_SIZE)+1  byte count, 0..RAM_SIZE.
abort  in  1  stop the current transfer; ignored when idle.
ram_readclk  out  1  read strobe to the driver.
ram_raddr  out  clog2(RAM_SIZE)  read address to the driver.
ram_outclk  in  1  read-data valid from the driver.
ram_out  in  BYTE_LEN  read data from the driver.
outclk  out  1  output byte valid, one-cycle pulse.
out  out  BYTE_LEN  output byte; held between pulses.
busy  out  1  high from start acceptance until the last in-flight read has returned.
done  out  1  one-cycle pulse coincident with the outclk of the final byte.

Behaviour:
- Reset: state=IDLE. ram_readclk=0, ram_raddr=0, outclk=0, out=0, busy=0, done=0, remaining=0, inflight=0, pace counter=0. Reset mid-transfer abandons everything. Read data returning after reset is ignored because inflight=0.
- States:
  - IDLE -> ISSUE on start with len>0.
  - ISSUE -> DRAIN after the final read is issued, or on abort.
  - DRAIN -> IDLE when inflight==0 and no ram_outclk is pending.
- start with len=0: no reads are issued; done pulses at cycle t+1; busy stays 0.
- start with len>0, sampled at cycle t:
  - busy=1 from t+1.
  - First ram_readclk at t+1, with ram_raddr=start_addr.
  - Subsequent reads follow every BYTE_PERIOD cycles (t+1+k*BYTE_PERIOD), len reads in total.
- start while busy=1 is ignored entirely; its inputs are not latched.
- Address arithmetic: next address = (addr+1==RAM_SIZE) ? 0 : addr+1. No modulo by power of two.
- ram_raddr holds its last value when ram_readclk=0.
- In-flight tracking: inflight counter, width clog2(READ_LATENCY/BYTE_PERIOD+2).
  - Increments on ram_readclk and decrements on ram_outclk.
  - Both in the same cycle: unchanged.
- Output path:
  - On ram_outclk with transfer not aborted: out<=ram_out, outclk=1 the next cycle.
  - Latency from ram_readclk to outclk is READ_LATENCY+1.
- done pulses with the outclk of byte len. busy falls in the same cycle as done (goes low at the cycle after the final ram_outclk).
- A new start is accepted in the cycle busy reads 0.
- abort:
  - In ISSUE or DRAIN, no further ram_readclk is issued from the next cycle.
  - ram_outclk for in-flight reads is consumed and suppressed: outclk stays 0.
  - done is never asserted for an aborted transfer.
  - busy drops once inflight reaches 0.
  - abort and start in the same cycle while IDLE: start wins and abort is ignored.
  - abort in the same cycle as the final issue: the read is still issued, its data is suppressed, and there is no done.
- len=RAM_SIZE: every location is read exactly once, wrapping back to just before start_addr.
- ram_outclk while inflight==0 (protocol error) is ignored; the counter saturates at 0.

Test Plan:
- READ_LATENCY=2, BYTE_PERIOD=4, RAM_SIZE=16, RAM preloaded with addr^0xA5. start at t0 with start_addr=3, len=4 -> ram_readclk at t0+1, +5, +9, +13 with addr 3,4,5,6. outclk at t0+4, +8, +12, +16 with out 0xA6,0xA1,0xA0,0xA3. done and busy fall at t0+16.
- Wrap: start_addr=14, len=4 -> ram_raddr sequence 14,15,0,1. Outputs 0xAB,0xAA,0xA5,0xA4. done coincides with the 4th outclk.
- len=0 -> done at t0+1, busy never rises, and no ram_readclk. Then start with len=1 in the next cycle -> accepted, one byte out.
- abort at t0+6 during len=8 (two reads issued) -> no ram_readclk after t0+6. outclk count=1 (the first byte only). busy low once the second read returns, and no done.
- start pulsed at t0+3 while busy -> ignored: the address sequence and count are unchanged from the first request.
- rst asserted mid-transfer at t0+7 -> all outputs 0 at t0+8. A late ram_outclk at t0+9 produces no outclk, and a fresh start then runs normally.
